addsub_seq_divider: RTL and testbench
=====================================

// Module: addsub_seq_divider
// PURPOSE
//  Multi-cycle unsigned 32-bit restoring divider. Sequences one shared add_sub instance in subtract
//  mode, one quotient bit per cycle. Sits beside the ALU as the divide path. Start/busy/done
//  handshake with registered quotient and remainder. Divide-by-zero is flagged and short-circuited.
// PARAMETERS
//  WIDTH   32   operand width; fixed at 32 (add_sub is 32-bit); other values are illegal
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE or DONE
//  dividend   in   32     captured on the accepted start edge
//  divisor    in   32     captured on the accepted start edge
//  busy       out  1      1 while iterating (state==CALC)
//  done       out  1      one-cycle pulse: results valid
//  div_zero   out  1      registered with results; 1 if divisor was 0
//  quotient   out  32     holds last result until next completion
//  remainder  out  32     holds last result until next completion
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=done=div_zero=0; quotient=remainder=0; work regs=0.
//  Reset mid-operation aborts the divide with no done pulse. Outputs read 0 after reset.
//  FSM:
//   IDLE -> CALC on start with divisor!=0.
//   IDLE -> DONE on start with divisor==0.
//   CALC -> DONE after 32 iterations.
//   DONE -> CALC/DONE on start (same rule as IDLE); else DONE -> IDLE.
//  Accept edge E0: Q<=dividend; B<=divisor; R<=0; cnt<=0.
//  Each CALC edge:
//   - sh = {R[30:0],Q[31]}.
//   - add_sub(select=1, a=sh, b=B) gives diff and carry (carry=1 means no borrow).
//   - accept = R[31] | carry. R[31]=1 means the true 33-bit shifted value is >= 2^32 > B.
//   - R <= accept ? diff : sh; Q <= {Q[30:0],accept}; cnt <= cnt+1.
//  Timing: edges E1..E32 iterate. At E32 (cnt==31): quotient<=final Q, remainder<=final R,
//   div_zero<=0, state<=DONE. done=1 for exactly the cycle after E32; busy=1 from E0 to E32.
//  Divide by zero: at E0 quotient<=32'hFFFFFFFF, remainder<=dividend, div_zero<=1, state<=DONE.
//   done=1 in the cycle after E0; busy stays 0.
//  start while busy is ignored: no queueing, operands not recaptured.
//  start during the DONE cycle is accepted (back-to-back); done drops next cycle.
//  quotient, remainder and div_zero change only on entry to DONE.
//  add_sub zero output unused. Unsigned only; signed handling belongs to the caller.
// STRUCTURE
//  Shared package: state encoding (IDLE, CALC, DONE; 2-bit), DIV_W=32, CNT_W=5, DIV0_Q=32'hFFFFFFFF.
//  One sub-module: existing add_sub, instantiated once, select tied to 1, a=sh, b=B.
//  Remaining logic inline: FSM, 5-bit counter, R/Q/B work regs, output regs.
// TESTING
//  1 100/7 -> quotient=14, remainder=2, div_zero=0; done exactly 33 cycles after start edge;
//    busy high 32 cycles.
//  2 32'hFFFFFFFF/1 -> q=32'hFFFFFFFF, r=0.
//    32'hFFFFFFFF/32'h80000001 -> q=1, r=32'h7FFFFFFE (exercises R[31] accept path).
//  3 32'h80000000/32'hFFFFFFFF -> q=0, r=32'h80000000; 0/5 -> q=0, r=0.
//  4 5/0 -> done 1 cycle after start, div_zero=1, q=32'hFFFFFFFF, r=5, busy never 1.
//  5 start 100/7, pulse start with 9/3 at iteration 10 -> ignored; result 14/2.
//    Then start 9/3 in the done cycle -> accepted; q=3, r=0 after 33 cycles.
//  6 assert rst at iteration 16 -> busy=done=0 immediately, outputs 0, no done pulse.
//    Fresh 50/8 afterwards -> q=6, r=2.

Source files
------------

// File: rtl/addsub_seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding, widths
// and the quotient value reported on divide-by-zero.
package addsub_seq_divider_pkg;

   localparam int DIV_W = 32;
   localparam int CNT_W = 5;
   localparam logic [DIV_W-1:0] DIV0_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_seq_divider_add_sub.sv
// 32-bit adder/subtractor: select=1 computes a-b with carry=1 meaning no borrow.
// Purely combinational; zero flag reflects the 32-bit result.
module add_sub
   import addsub_seq_divider_pkg::*;
(
   input  logic             i_select,
   input  logic [DIV_W-1:0] i_a,
   input  logic [DIV_W-1:0] i_b,
   output logic [DIV_W-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero
);

   logic [DIV_W-1:0] w_b_eff;
   logic [DIV_W:0]   w_sum;

   assign w_b_eff  = i_select ? ~i_b : i_b;
   assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{DIV_W{1'b0}}, i_select};
   assign o_result = w_sum[DIV_W-1:0];
   assign o_carry  = w_sum[DIV_W];
   assign o_zero   = (w_sum[DIV_W-1:0] == '0);

endmodule

// File: rtl/addsub_seq_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle through a shared add_sub.
// Start accepted in IDLE/DONE; done pulses 33 cycles after accept (1 cycle for divide-by-zero).
module addsub_seq_divider
   import addsub_seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_q;
   logic [DIV_W-1:0] r_b;
   logic [DIV_W-1:0] r_rem;
   logic [DIV_W-1:0] r_quotient;
   logic [DIV_W-1:0] r_remainder;
   logic             r_div_zero;

   logic [DIV_W-1:0] w_sh;
   logic [DIV_W-1:0] w_diff;
   logic             w_carry;
   logic             w_unused_zero;
   logic             w_take;
   logic [DIV_W-1:0] w_r_next;
   logic [DIV_W-1:0] w_q_next;
   logic             w_accept;
   logic             w_last;
   logic             w_busy;
   logic             w_done;

   assign w_sh = {r_rem[DIV_W-2:0], r_q[DIV_W-1]};

   add_sub u_add_sub (
      .i_select (1'b1),
      .i_a      (w_sh),
      .i_b      (r_b),
      .o_result (w_diff),
      .o_carry  (w_carry),
      .o_zero   (w_unused_zero)
   );

   // A set R[31] means the shifted partial remainder is really 33 bits, so it exceeds B.
   assign w_take   = r_rem[DIV_W-1] | w_carry;
   assign w_r_next = w_take ? w_diff : w_sh;
   assign w_q_next = {r_q[DIV_W-2:0], w_take};
   assign w_last   = &r_cnt;
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = (divisor == '0) ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            w_busy = 1'b1;
            if (w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            w_done = 1'b1;
            if (start) w_next_state = (divisor == '0) ? ST_DONE : ST_CALC;
            else       w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_q         <= '0;
         r_b         <= '0;
         r_rem       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
      end else if (w_accept) begin
         r_q   <= dividend;
         r_b   <= divisor;
         r_rem <= '0;
         r_cnt <= '0;
         if (divisor == '0) begin
            r_quotient  <= DIV0_Q;
            r_remainder <= dividend;
            r_div_zero  <= 1'b1;
         end
      end else if (r_state == ST_CALC) begin
         r_rem <= w_r_next;
         r_q   <= w_q_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_div_zero  <= 1'b0;
         end
      end
   end

   assign busy      = w_busy;
   assign done      = w_done;
   assign div_zero  = r_div_zero;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule

// File: tb/tb_addsub_seq_divider.sv
// Bench for addsub_seq_divider: directed table, random operands against a / and % model,
// and hand sequences for ignored start, back-to-back start and mid-operation reset.
module tb_addsub_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_cmp = 0;
   int n_err = 0;

   addsub_seq_divider #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned arithmetic, divide-by-zero returns all-ones / dividend.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called just after the accept edge; lat counts cycles from that edge to done.
   task automatic wait_done(output int lat, output int bcnt, output bit ok);
      lat = 1; bcnt = 0; ok = 1'b0;
      while (lat <= 40) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         bcnt += int'(busy);
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input logic edz);
      int lat, bcnt;
      bit ok;
      start_op(a, b);
      wait_done(lat, bcnt, ok);
      check({tag, ".done_seen"}, {31'd0, ok}, 32'd1);
      check({tag, ".latency"}, lat, (b == 32'd0) ? 32'd1 : 32'd33);
      check({tag, ".busy_cycles"}, bcnt, (b == 32'd0) ? 32'd0 : 32'd32);
      check({tag, ".quotient"}, quotient, eq);
      check({tag, ".remainder"}, remainder, er);
      check({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, edz});
      @(posedge clk); #1;
      check({tag, ".done_drop"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      vec_t        tbl[7];
      logic [31:0] a, b, eq, er;
      logic        edz;
      int          lat, bcnt, dcnt;
      bit          ok;

      tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      tbl[2] = '{32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};
      tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      tbl[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
      tbl[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
      tbl[6] = '{32'd50,         32'd8,          32'd6,          32'd2,          1'b0};

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      check("reset.busy", {31'd0, busy}, 32'd0);
      check("reset.done", {31'd0, done}, 32'd0);
      check("reset.div_zero", {31'd0, div_zero}, 32'd0);
      check("reset.quotient", quotient, 32'd0);
      check("reset.remainder", remainder, 32'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom_range(1, 15);
            1:       b = $urandom;
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : (a >> $urandom_range(0, 4));
         endcase
         ref_div(a, b, eq, er, edz);
         run_check($sformatf("rnd%0d", i), a, b, eq, er, edz);
      end

      // start while busy must be ignored
      start_op(32'd100, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      check("ignore.busy", {31'd0, busy}, 32'd1);
      wait_done(lat, bcnt, ok);
      check("ignore.done_seen", {31'd0, ok}, 32'd1);
      check("ignore.quotient", quotient, 32'd14);
      check("ignore.remainder", remainder, 32'd2);

      // start in the done cycle is taken back-to-back
      @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      check("b2b.done_drop", {31'd0, done}, 32'd0);
      check("b2b.busy", {31'd0, busy}, 32'd1);
      check("b2b.quotient_held", quotient, 32'd14);
      wait_done(lat, bcnt, ok);
      check("b2b.done_seen", {31'd0, ok}, 32'd1);
      check("b2b.latency", lat, 32'd33);
      check("b2b.quotient", quotient, 32'd3);
      check("b2b.remainder", remainder, 32'd0);

      // reset in the middle of an operation
      start_op(32'd100, 32'd7);
      repeat (15) begin @(posedge clk); #1; end
      @(negedge clk); rst = 1'b1; #1;
      check("midrst.busy", {31'd0, busy}, 32'd0);
      check("midrst.done", {31'd0, done}, 32'd0);
      check("midrst.quotient", quotient, 32'd0);
      check("midrst.remainder", remainder, 32'd0);
      check("midrst.div_zero", {31'd0, div_zero}, 32'd0);
      @(negedge clk); rst = 1'b0;
      dcnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         dcnt += int'(done) + int'(busy);
      end
      check("midrst.no_activity", dcnt, 32'd0);
      run_check("after_rst", 32'd50, 32'd8, 32'd6, 32'd2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
